bit_window_monitor: RTL
=======================

BIT_WINDOW_MONITOR -- requirements
Module: bit_window_monitor

Interface
REQ-001 SHALL have parameter WINDOW, default 16, meaning the number of accepted count beats per window (legal range 2..16).
REQ-002 SHALL have parameter THRESH, default 16, meaning the disparity magnitude above which a window is flagged imbalanced (legal range 0..128).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: upstream per-byte ones-count is valid.
REQ-006 SHALL have port in_count, input, 4 bits: ones-count of one 8-bit word (legal 0..8).
REQ-007 SHALL have port in_ready, output, 1 bit: block accepts a beat this cycle.
REQ-008 SHALL have port out_valid, output, 1 bit: window result is held on the out_* ports.
REQ-009 SHALL have port out_ready, input, 1 bit: downstream consumes the result.
REQ-010 SHALL have port out_total, output, 8 bits: unsigned sum of the window's counts (0..128).
REQ-011 SHALL have port out_disparity, output, 9 bits: two's-complement value 2*out_total - 8*WINDOW.
REQ-012 SHALL have port out_imbalanced, output, 1 bit: |out_disparity| > THRESH.
REQ-013 SHALL have port err_sticky, output, 1 bit: an illegal in_count (>8) was seen since reset.

Function
REQ-014 SHALL implement a two-state FSM: ACCUM (in_ready=1, out_valid=0) and REPORT (in_ready=0, out_valid=1).
REQ-015 SHALL, in ACCUM, accept a beat only on a cycle where in_valid=1 and add in_count to the accumulator; in_valid gaps leave all state unchanged.
REQ-016 SHALL saturate any in_count >8 to 8 before accumulation and set err_sticky on that same edge.
REQ-017 SHALL, on the edge accepting beat number WINDOW, register out_total, out_disparity and out_imbalanced (including that beat) and enter REPORT, so out_valid rises in the cycle after the final accept.
REQ-018 SHALL hold out_total, out_disparity and out_imbalanced stable while out_valid=1 and out_ready=0.
REQ-019 SHALL, in REPORT, on an edge with out_ready=1, return to ACCUM with the accumulator and beat counter cleared; in_ready=1 in the following cycle.
REQ-020 SHALL never accept a beat in REPORT; because in_ready=0 there, accept and report never occur on the same cycle.
REQ-021 SHALL size the beat counter at 5 bits and the accumulator at 8 bits; neither wraps for legal parameters.
REQ-022 SHALL compute disparity in 9-bit signed arithmetic without overflow: -128..+128.

Reset
REQ-023 SHALL, while reset=1, force state=ACCUM, accumulator=0, beat counter=0, out_valid=0, out_total=0, out_disparity=0, out_imbalanced=0, err_sticky=0, in_ready=1.
REQ-024 SHALL discard any partial window or pending result when reset is asserted mid-operation; the next window needs a full WINDOW beats.
REQ-025 SHALL clear err_sticky only by reset.

Structure
REQ-026 SHALL take from the shared package bitbal_pkg the FSM state enum type and the constants WORD_W=8, COUNT_W=4 and MAX_COUNT=8.
REQ-027 SHALL contain one sub-module, window_counter: the beat counter with clear/increment and a terminal flag at WINDOW-1.

Verification
REQ-028 SHALL cover: 16 beats of count 4 -> out_total=64, out_disparity=0, out_imbalanced=0, out_valid one cycle after the 16th accept.
REQ-029 SHALL cover: 16 beats of count 8 -> out_total=128, out_disparity=+128, out_imbalanced=1; then 16 beats of 0 -> out_total=0, out_disparity=-128, out_imbalanced=1.
REQ-030 SHALL cover: result pending with out_ready=0 for 10 cycles -> outputs stable and in_ready=0 throughout; out_ready=1 -> in_ready=1 the next cycle.
REQ-031 SHALL cover: in_count=12 in a window of otherwise 4s -> it counts as 8, out_total=68, out_disparity=+8, and err_sticky=1 until reset.
REQ-032 SHALL cover: reset after 5 accepted beats -> outputs zero; 15 further beats produce no out_valid and the 16th beat produces it.
REQ-033 SHALL cover: in_valid toggling every other cycle -> the same result as back-to-back input, with gaps not counted as beats.

Source files
------------

// File: rtl/bitbal_pkg.sv
// Shared constants and types for the bit-balance monitoring blocks.
package bitbal_pkg;

    localparam int WORD_W    = 8;
    localparam int COUNT_W   = 4;
    localparam int MAX_COUNT = 8;
    localparam int BEAT_W    = 5;

    typedef enum logic {
        ACCUM  = 1'b0,
        REPORT = 1'b1
    } state_t;

    // A byte cannot hold more than MAX_COUNT ones, so larger counts are clipped.
    function automatic logic [COUNT_W-1:0] saturate_count(input logic [COUNT_W-1:0] count);
        return (count > COUNT_W'(MAX_COUNT)) ? COUNT_W'(MAX_COUNT) : count;
    endfunction

endpackage

// File: rtl/window_counter.sv
// Beat counter for one window; terminal marks the last beat of the window.
module window_counter
    import bitbal_pkg::*;
#(
    parameter int WINDOW = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic incr,
    output logic terminal
);

    logic [BEAT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (incr) begin
            count <= count + 1'b1;
        end
    end

    assign terminal = (count == BEAT_W'(WINDOW - 1));

endmodule

// File: rtl/bit_window_monitor.sv
// Sums per-byte ones-counts over a window of beats and reports total,
// disparity from a perfect 50% balance, and an imbalance flag.
module bit_window_monitor
    import bitbal_pkg::*;
#(
    parameter int WINDOW = 16,
    parameter int THRESH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [COUNT_W-1:0] in_count,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WORD_W-1:0]  out_total,
    output logic [WORD_W:0]    out_disparity,
    output logic               out_imbalanced,
    output logic               err_sticky
);

    localparam logic [WORD_W:0] BALANCE = (WORD_W + 1)'(MAX_COUNT * WINDOW);

    state_t              state;
    state_t              state_next;
    logic [WORD_W-1:0]   acc;
    logic [WORD_W-1:0]   sum_next;
    logic [WORD_W:0]     disp_next;
    logic [WORD_W:0]     disp_mag;
    logic                accept;
    logic                last_beat;
    logic                consume;
    logic                window_clear;
    logic                terminal;

    assign accept       = (state == ACCUM) && in_valid;
    assign last_beat    = accept && terminal;
    assign consume      = (state == REPORT) && out_ready;
    assign window_clear = last_beat || consume;

    // Disparity is 2*total - 8*WINDOW; modulo-512 subtraction gives the 9-bit two's complement.
    assign sum_next  = acc + WORD_W'(saturate_count(in_count));
    assign disp_next = {sum_next, 1'b0} - BALANCE;
    assign disp_mag  = disp_next[WORD_W] ? -disp_next : disp_next;

    window_counter #(
        .WINDOW (WINDOW)
    ) u_window_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (window_clear),
        .incr     (accept),
        .terminal (terminal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (last_beat) begin
                    state_next = REPORT;
                end
            end
            REPORT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = ACCUM;
                end
            end
            default: state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (window_clear) begin
            acc <= '0;
        end else if (accept) begin
            acc <= sum_next;
        end
    end

    // Result registers only load on the final beat, so they stay frozen through REPORT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_total      <= '0;
            out_disparity  <= '0;
            out_imbalanced <= 1'b0;
        end else if (last_beat) begin
            out_total      <= sum_next;
            out_disparity  <= disp_next;
            out_imbalanced <= (disp_mag > (WORD_W + 1)'(THRESH));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_sticky <= 1'b0;
        end else if (accept && (in_count > COUNT_W'(MAX_COUNT))) begin
            err_sticky <= 1'b1;
        end
    end

endmodule
